kbd_fifo4: RTL

- 4-entry, 16-bit-wide first-word-fall-through FIFO.
- Buffers keyboard scan words between the MiSTer PS/2 front end and the Hack KBD memory-mapped register.
- Storage is four 16-bit registers; the read word is selected by a 4-way 16-bit mux driven by the 2-bit read pointer.
- Downstream logic sees the head word combinationally and pops it with a one-cycle strobe.

---
 rtl/kbd_fifo4_pkg.sv | 19 +
 rtl/kbd_fifo4_reg_bank4x16.sv | 55 +++++
 rtl/kbd_fifo4.sv | 91 +++++++++
 3 files changed

// File: rtl/kbd_fifo4_pkg.sv
// Shared constants and types for the keyboard scan-word FIFO.
// The optional sticky error flag is enabled with `define KBD_FIFO4_ERR_FLAG_EN.
package kbd_fifo4_pkg;

  localparam int KBD_FIFO_DEPTH = 4;
  localparam int KBD_PTR_W      = 2;
  localparam int KBD_CNT_W      = 3;
  localparam int KBD_WORD_W     = 16;

  typedef logic [KBD_WORD_W-1:0] kbd_word_t;
  typedef logic [KBD_PTR_W-1:0]  kbd_ptr_t;
  typedef logic [KBD_CNT_W-1:0]  kbd_cnt_t;

  // Pointer advance; the 2-bit width gives the 3 -> 0 wrap for free.
  function automatic kbd_ptr_t kbd_ptr_inc(input kbd_ptr_t p);
    return p + kbd_ptr_t'(1);
  endfunction

endpackage

// File: rtl/kbd_fifo4_reg_bank4x16.sv
// Four-entry storage for kbd_fifo4: write decoder on wr_ptr gated by the
// accepted-push strobe, and a 4-way read mux on rd_ptr. Storage has no reset;
// the FIFO control masks stale contents through its empty flag.
module reg_bank4x16
  import kbd_fifo4_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             wr_stb,
  input  logic [1:0]       wr_ptr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       rd_ptr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem0;
  logic [WIDTH-1:0] mem1;
  logic [WIDTH-1:0] mem2;
  logic [WIDTH-1:0] mem3;
  logic [KBD_FIFO_DEPTH-1:0] wr_sel;

  // One-hot write decode, only active on an accepted push.
  always_comb begin
    wr_sel = '0;
    if (wr_stb) begin
      unique case (wr_ptr)
        2'd0:    wr_sel = 4'b0001;
        2'd1:    wr_sel = 4'b0010;
        2'd2:    wr_sel = 4'b0100;
        default: wr_sel = 4'b1000;
      endcase
    end
  end

  // Data registers load on their decoded select.
  always_ff @(posedge clk) begin
    if (wr_sel[0]) mem0 <= wr_data;
    if (wr_sel[1]) mem1 <= wr_data;
    if (wr_sel[2]) mem2 <= wr_data;
    if (wr_sel[3]) mem3 <= wr_data;
  end

  // Head-word read mux.
  always_comb begin
    rd_data = mem0;
    unique case (rd_ptr)
      2'd0:    rd_data = mem0;
      2'd1:    rd_data = mem1;
      2'd2:    rd_data = mem2;
      default: rd_data = mem3;
    endcase
  end

endmodule

// File: rtl/kbd_fifo4.sv
// 4-entry first-word-fall-through FIFO buffering keyboard scan words between
// the PS/2 front end and the KBD register. Head word is visible combinationally
// and popped with a one-cycle rd_en strobe. A push while full is accepted only
// when a pop frees the head slot in the same cycle.
// Optional: `define KBD_FIFO4_ERR_FLAG_EN adds a sticky err output that flags
// dropped pushes and ignored pops until reset.
module kbd_fifo4
  import kbd_fifo4_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
`ifdef KBD_FIFO4_ERR_FLAG_EN
  output logic [2:0]       count,
  output logic             err
`else
  output logic [2:0]       count
`endif
);

  kbd_ptr_t         wr_ptr;
  kbd_ptr_t         rd_ptr;
  kbd_cnt_t         cnt_q;
  logic             acc_wr;
  logic             acc_rd;
  logic [WIDTH-1:0] bank_rd;

  // Flags come straight from the registered count, so they never see wr_en/rd_en.
  assign count = cnt_q;
  assign empty = (cnt_q == kbd_cnt_t'(0));
  assign full  = (cnt_q == kbd_cnt_t'(KBD_FIFO_DEPTH));

  // Accept logic: a full queue still takes a push when the head is popped
  // in the same cycle, since the write then lands in the vacated slot.
  always_comb begin
    acc_rd = rd_en & ~empty;
    acc_wr = wr_en & (~full | rd_en);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (acc_wr) wr_ptr <= kbd_ptr_inc(wr_ptr);
      if (acc_rd) rd_ptr <= kbd_ptr_inc(rd_ptr);
      unique case ({acc_wr, acc_rd})
        2'b10:   cnt_q <= cnt_q + kbd_cnt_t'(1);
        2'b01:   cnt_q <= cnt_q - kbd_cnt_t'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  reg_bank4x16 #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk    (clk),
    .wr_stb (acc_wr),
    .wr_ptr (wr_ptr),
    .wr_data(wr_data),
    .rd_ptr (rd_ptr),
    .rd_data(bank_rd)
  );

  // Empty queue reads as zero rather than whatever stale word the slot holds.
  always_comb begin
    rd_data = empty ? '0 : bank_rd;
  end

`ifdef KBD_FIFO4_ERR_FLAG_EN
  // Sticky error: dropped push (full, no pop) or pop of an empty queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if ((wr_en & full & ~rd_en) | (rd_en & empty)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule
